// File: rtl/bus_arbiter_if.sv
// bus_arbiter_if: request/grant bundle between the datapath sources, the
// round-robin arbiter and the bus select encoder.
//   req        per-source drive request (sources -> arbiter)
//   grant      one-hot out-enables (arbiter -> encoder)
//   grant_idx  binary index of the current owner
//   busy       arbiter holds a grant
//   conflict   two or more requests were seen at a decision
//   timeout    forced release by the watchdog
// Modports: master = arbiter side, slave = sources/encoder side.
interface bus_arbiter_if #(
   parameter int unsigned N_SRC = 24,
   parameter int unsigned IDX_W = 5
);
   logic [N_SRC-1:0] req;
   logic [N_SRC-1:0] grant;
   logic [IDX_W-1:0] grant_idx;
   logic             busy;
   logic             conflict;
   logic             timeout;

   modport master (
      input  req,
      output grant, grant_idx, busy, conflict, timeout
   );

   modport slave (
      output req,
      input  grant, grant_idx, busy, conflict, timeout
   );
endinterface

// File: rtl/bus_arbiter.sv
// bus_arbiter: registered round-robin arbiter feeding the bus select encoder.
// Issues at most one one-hot out-enable per cycle, holds each grant for at
// least HOLD_MIN cycles, and inserts a one-cycle all-zero turnaround between
// owners so the encoder never sees overlapping enables.
// Ports:
//   clk  system clock, rising edge
//   clr  synchronous active-high reset
//   bus  bus_arbiter_if.master (req in; grant, grant_idx, busy, conflict,
//        timeout out)
// Optional feature: define BUS_ARB_TIMEOUT_EN to enable the MAX_HOLD watchdog;
// without it timeout is tied low and an owner keeps the bus while req stays high.
module bus_arbiter #(
   parameter int unsigned N_SRC    = 24,
   parameter int unsigned IDX_W    = 5,
   parameter int unsigned HOLD_MIN = 1,
   parameter int unsigned MAX_HOLD = 16
) (
   input logic           clk,
   input logic           clr,
   bus_arbiter_if.master bus
);

   localparam logic [1:0] StIdle  = 2'd0;
   localparam logic [1:0] StGrant = 2'd1;
   localparam logic [1:0] StTurn  = 2'd2;

   // One extra bit so last_idx + 1 + offset never overflows before the wrap.
   localparam int unsigned     SW       = IDX_W + 1;
   localparam logic [SW-1:0]   NSrcW    = SW'(N_SRC);
   localparam logic [7:0]      HoldMinC = 8'(HOLD_MIN);

   if (N_SRC < 1 || N_SRC > 32 || (2 ** IDX_W) < N_SRC || HOLD_MIN < 1 || HOLD_MIN > 255 ||
       MAX_HOLD < 1 || MAX_HOLD > 255) begin : gen_bad_params
      $error("bus_arbiter: illegal parameter set");
   end

   logic [1:0]       state_q, state_d;
   logic [N_SRC-1:0] grant_q, grant_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [IDX_W-1:0] last_q, last_d;
   logic [7:0]       cnt_q, cnt_d;
   logic             conflict_q, conflict_d;
`ifdef BUS_ARB_TIMEOUT_EN
   localparam logic [7:0] MaxHoldC = 8'(MAX_HOLD);
   logic             timeout_q, timeout_d;
`endif

   logic [N_SRC-1:0] req_rot;
   logic [SW-1:0]    start, off, sum;
   logic [IDX_W-1:0] pick;
   logic             multi_req;
   logic             owner_req;

   // Round-robin pick: rotate req so bit 0 is last_idx+1, take the lowest
   // set bit, then map the offset back modulo N_SRC.
   always_comb begin
      start   = {1'b0, last_q} + SW'(1);
      req_rot = N_SRC'({bus.req, bus.req} >> start);
      off     = '0;
      for (int j = N_SRC - 1; j >= 0; j--) begin
         if (req_rot[j]) off = SW'(j);
      end
      sum = start + off;
      if (sum >= NSrcW) sum = sum - NSrcW;
      pick = sum[IDX_W-1:0];
   end

   // Clearing the lowest set bit leaves something only if two or more were set.
   assign multi_req = |(bus.req & (bus.req - N_SRC'(1)));
   assign owner_req = |(grant_q & bus.req);

   always_comb begin
      state_d    = state_q;
      grant_d    = grant_q;
      idx_d      = idx_q;
      last_d     = last_q;
      cnt_d      = cnt_q;
      conflict_d = 1'b0;
`ifdef BUS_ARB_TIMEOUT_EN
      timeout_d  = 1'b0;
`endif
      unique case (state_q)
         StIdle: begin
            if (bus.req != '0) begin
               grant_d    = N_SRC'(1) << pick;
               idx_d      = pick;
               last_d     = pick;
               cnt_d      = 8'd1;
               conflict_d = multi_req;
               state_d    = StGrant;
            end
         end
         StGrant: begin
            if (!owner_req && cnt_q >= HoldMinC) begin
               grant_d = '0;
               idx_d   = '0;
               state_d = StTurn;
`ifdef BUS_ARB_TIMEOUT_EN
            end else if (owner_req && cnt_q >= MaxHoldC) begin
               grant_d   = '0;
               idx_d     = '0;
               timeout_d = 1'b1;
               state_d   = StTurn;
`endif
            end else if (cnt_q != 8'hff) begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         StTurn: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
            grant_d = '0;
            idx_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         state_q    <= StIdle;
         grant_q    <= '0;
         idx_q      <= '0;
         last_q     <= IDX_W'(N_SRC - 1);
         cnt_q      <= '0;
         conflict_q <= 1'b0;
`ifdef BUS_ARB_TIMEOUT_EN
         timeout_q  <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         grant_q    <= grant_d;
         idx_q      <= idx_d;
         last_q     <= last_d;
         cnt_q      <= cnt_d;
         conflict_q <= conflict_d;
`ifdef BUS_ARB_TIMEOUT_EN
         timeout_q  <= timeout_d;
`endif
      end
   end

   assign bus.grant     = grant_q;
   assign bus.grant_idx = idx_q;
   assign bus.busy      = (state_q == StGrant);
   assign bus.conflict  = conflict_q;
`ifdef BUS_ARB_TIMEOUT_EN
   assign bus.timeout   = timeout_q;
`else
   assign bus.timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed and random stimulus for bus_arbiter. A reference
// model predicts the outputs after every edge and queues them; a separate
// monitor pops and compares after each rising edge.
module tb_bus_arbiter;
   localparam int unsigned N    = 24;
   localparam int unsigned IW   = 5;
   localparam int unsigned HMIN = 3;
   localparam int unsigned MAXH = 4;

   typedef struct packed {
      logic [N-1:0]  grant;
      logic [IW-1:0] idx;
      logic          busy;
      logic          conflict;
      logic          timeout;
   } exp_t;

   logic clk = 1'b0;
   logic clr = 1'b1;

   bus_arbiter_if #(.N_SRC(N), .IDX_W(IW)) bus ();

   bus_arbiter #(
      .N_SRC   (N),
      .IDX_W   (IW),
      .HOLD_MIN(HMIN),
      .MAX_HOLD(MAXH)
   ) dut (
      .clk(clk),
      .clr(clr),
      .bus(bus)
   );

   always #5 clk = ~clk;

   exp_t expq[$];
   int   n_checks = 0;
   int   n_err    = 0;

   // Reference model: who owns the bus, for how many cycles, whether a
   // turnaround is pending, and who owned it last.
   int   m_owner = -1;
   int   m_held  = 0;
   int   m_last  = N - 1;
   bit   m_turn  = 1'b0;

   logic [N-1:0] pend = '0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      n_checks++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, want, $time);
      end
   endtask

   task automatic model_step(input bit c, input logic [N-1:0] r, output exp_t e);
      bit conf = 1'b0;
      bit to   = 1'b0;
      bit found;
      if (c) begin
         m_owner = -1;
         m_held  = 0;
         m_turn  = 1'b0;
         m_last  = N - 1;
      end else if (m_owner >= 0) begin
         if (!r[m_owner] && m_held >= HMIN) begin
            m_owner = -1;
            m_turn  = 1'b1;
`ifdef BUS_ARB_TIMEOUT_EN
         end else if (r[m_owner] && m_held >= MAXH) begin
            m_owner = -1;
            m_turn  = 1'b1;
            to      = 1'b1;
`endif
         end else if (m_held < 255) begin
            m_held++;
         end
      end else if (m_turn) begin
         m_turn = 1'b0;
      end else if (r != '0) begin
         found = 1'b0;
         for (int i = 1; i <= N; i++) begin
            int cand;
            cand = (m_last + i) % N;
            if (!found && r[cand]) begin
               found   = 1'b1;
               m_owner = cand;
            end
         end
         m_last = m_owner;
         m_held = 1;
         conf   = ($countones(r) >= 2);
      end
      e.grant    = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
      e.idx      = (m_owner >= 0) ? IW'(m_owner) : '0;
      e.busy     = (m_owner >= 0);
      e.conflict = conf;
      e.timeout  = to;
   endtask

   // Inputs change on the falling edge, so the next rising edge samples them.
   task automatic drive(input bit c, input logic [N-1:0] r);
      exp_t e;
      @(negedge clk);
      clr     = c;
      bus.req = r;
      model_step(c, r, e);
      expq.push_back(e);
   endtask

   // Monitor
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (expq.size() > 0) begin
            e = expq.pop_front();
            check("grant",     32'(bus.grant),     32'(e.grant));
            check("grant_idx", 32'(bus.grant_idx), 32'(e.idx));
            check("busy",      32'(bus.busy),      32'(e.busy));
            check("conflict",  32'(bus.conflict),  32'(e.conflict));
            check("timeout",   32'(bus.timeout),   32'(e.timeout));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "tb_bus_arbiter watchdog expired");
   end

   initial begin
      logic [N-1:0] rr_mask;
      bus.req = '0;

      // Reset, then a lone request from PC (bit 18).
      repeat (2) drive(1'b1, '0);
      repeat (3) drive(1'b0, N'(1) << 18);
      repeat (4) drive(1'b0, '0);

      // Round robin over 0, 5, 23; each owner drops its bit while granted.
      rr_mask = (N'(1) << 0) | (N'(1) << 5) | (N'(1) << 23);
      for (int k = 0; k < 22; k++) begin
         drive(1'b0, (m_owner >= 0) ? (rr_mask & ~(N'(1) << m_owner)) : rr_mask);
      end
      repeat (3) drive(1'b0, '0);

      // One-cycle request still gets the minimum hold.
      drive(1'b0, N'(1) << 4);
      repeat (6) drive(1'b0, '0);

      // Reset in the second grant cycle of InPort (bit 20).
      repeat (2) drive(1'b0, N'(1) << 20);
      drive(1'b1, N'(1) << 20);
      drive(1'b0, (N'(1) << 0) | (N'(1) << 5));
      repeat (6) drive(1'b0, '0);

      // Wrap-around: last owner 23, then 2 and 22 compete.
      drive(1'b0, N'(1) << 23);
      repeat (5) drive(1'b0, '0);
      drive(1'b0, (N'(1) << 2) | (N'(1) << 22));
      repeat (6) drive(1'b0, '0);

      // Permanent request from bit 7 (watchdog case when enabled).
      repeat (14) drive(1'b0, N'(1) << 7);
      repeat (4) drive(1'b0, '0);

      // Random traffic: sources raise requests, owners sometimes release.
      drive(1'b1, '0);
      pend = '0;
      for (int cyc = 0; cyc < 800; cyc++) begin
         if ($urandom_range(0, 2) == 0) pend[$urandom_range(0, N - 1)] = 1'b1;
         if (m_owner >= 0 && $urandom_range(0, 2) == 0) pend[m_owner] = 1'b0;
         if ($urandom_range(0, 15) == 0) pend[$urandom_range(0, N - 1)] = 1'b0;
         if ($urandom_range(0, 99) == 0) begin
            drive(1'b1, pend);
         end else begin
            drive(1'b0, pend);
         end
      end

      drive(1'b0, '0);
      repeat (3) @(posedge clk);
      #2;
      check("queue_drained", 32'(expq.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Registered, round-robin bus-source arbiter that sits directly upstream of the bus select encoder.
- Takes raw drive requests from the datapath sources and issues at most one registered, one-hot out-enable per cycle, so the encoder never sees overlapping enables.
- Grant bit order matches the encoder inputs: r0..r15 = bits 0..15, HI=16, LO=17, PC=18, MDR=19, InPort=20, Zhigh=21, Zlow=22, C=23.
- Inserts one idle turnaround cycle between owners and flags contention.

Parameters:
- N_SRC, 24, number of bus sources (1..32).
- IDX_W, 5, width of grant_idx; must satisfy 2^IDX_W >= N_SRC.
- HOLD_MIN, 1, minimum cycles a grant is held once issued (>=1).
- MAX_HOLD, 16, watchdog limit in cycles; used only when BUS_ARB_TIMEOUT_EN is defined.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- clr  input  1  synchronous active-high reset.
- req  input  N_SRC  per-source drive request; level-sensitive, held while the source wants the bus.
- grant  output  N_SRC  registered one-hot out-enables to the encoder; all-zero when no owner.
- grant_idx  output  IDX_W  binary index of current owner; 0 when grant is all-zero.
- busy  output  1  high while state is GRANT.
- conflict  output  1  one-cycle pulse when two or more req bits are high at an arbitration decision.
- timeout  output  1  one-cycle pulse on forced release (BUS_ARB_TIMEOUT_EN only; otherwise tied 0).

Behaviour:
- Reset:
  - clr sampled high -> state IDLE; grant=0, grant_idx=0, busy=0, conflict=0, timeout=0; hold counter=0; last_idx=N_SRC-1, so bit 0 wins first.
  - clr overrides everything, including a grant held mid-operation; grant drops on the same edge.
- States: IDLE, GRANT, TURN.
- IDLE:
  - If req != 0: pick the first set bit scanning upward from last_idx+1, wrapping modulo N_SRC.
  - Register the one-hot grant and grant_idx, set last_idx to the winner, load hold counter=1, go to GRANT.
  - Latency: req high at edge k -> grant visible after edge k.
  - If req == 0: stay in IDLE with outputs zero.
- conflict: asserted for the single cycle following a decision edge at which popcount(req) >= 2. Never asserted in GRANT or TURN.
- GRANT:
  - Counter increments each cycle and saturates at 2^8-1.
  - Release when req[owner]==0 and counter >= HOLD_MIN. On release: grant=0, grant_idx=0, busy=0, go to TURN.
  - If req[owner] drops before HOLD_MIN, the grant stays until the counter reaches HOLD_MIN.
  - Requests from other sources are ignored (no preemption).
- TURN: exactly one cycle with grant=0, then return to IDLE. Requests are not sampled in TURN.
- Back-to-back: minimum gap between two owners is 2 idle-grant cycles (TURN + IDLE decision). Any grant change passes through all-zero.
- Invariants:
  - grant has popcount <= 1 in every cycle.
  - grant_idx always equals the encoded grant.
  - req bits at or above N_SRC do not exist; no X-propagation from unused index values.

Optional Feature:
- BUS_ARB_TIMEOUT_EN defined:
  - In GRANT, if the counter reaches MAX_HOLD while req[owner] is still high, force release (go to TURN as for a normal release) and pulse timeout for one cycle.
  - Rotation then advances past that owner.
- Not defined: no watchdog; an owner keeps the bus indefinitely while req stays high. timeout is constant 0, and MAX_HOLD has no effect.

Test Plan:
- Reset then single request: clr for 2 cycles, req=bit18 (PC) for 3 cycles -> grant=0x040000 and grant_idx=18 from the cycle after req, busy=1; after req drops, one TURN cycle with grant=0.
- Round-robin, 3 sources: req bits 0, 5, 23 held high, pulsing each owner's bit low when granted -> grant order 0, 5, 23, 0; conflict pulses on each decision where >=2 bits are set.
- HOLD_MIN=3: req bit 4 high for 1 cycle -> grant bit 4 held exactly 3 cycles, then TURN, then IDLE.
- Reset mid-grant: owner 20 (InPort) granted, clr asserted in the 2nd grant cycle -> grant=0 and grant_idx=0 after that edge; next decision picks bit 0 if requested.
- Wrap-around: last owner 23, then req bits 2 and 22 -> grant goes to 2 (scan 0..22 after wrap finds 2 first), conflict=1.
- With BUS_ARB_TIMEOUT_EN and MAX_HOLD=4: req bit 7 held high permanently -> grant for 4 cycles, timeout pulse, TURN, then re-grant to 7 if it is the only requester.
